conv_stream_feeder: RTL

//  Transmit side of the convolver stream interface. On start, reads a K*K kernel and a FM_ROW*FM_COL

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_stream_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolver stream feeder: state encodings, data width
// and the job-size constants derived from the layer geometry.
package conv_pkg;

   localparam int DATA_W = 16;

   typedef logic [2:0] state_t;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD_W = 3'd1;
   localparam logic [2:0] FEED_A = 3'd2;
   localparam logic [2:0] DRAIN  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   function automatic int calc_nw(input int k);
      return k * k;
   endfunction

   function automatic int calc_na(input int fm_row, input int fm_col);
      return fm_row * fm_col;
   endfunction

   function automatic int calc_out_n(input int fm_row, input int fm_col, input int k, input int s);
      return ((fm_row - k) / s + 1) * ((fm_col - k) / s + 1);
   endfunction

   // Bits needed to hold values 0..maxv.
   function automatic int cnt_w(input int maxv);
      return (maxv < 1) ? 1 : $clog2(maxv + 1);
   endfunction

endpackage

// File: rtl/conv_stream_feeder.sv
// Transmit side of the convolver stream: reads kernel and activation map from a
// 1-cycle-latency buffer, streams them to the convolver and audits its outputs.
module conv_stream_feeder
   import conv_pkg::*;
#(
   parameter int FM_ROW   = 10,
   parameter int FM_COL   = 10,
   parameter int K        = 3,
   parameter int S        = 1,
   parameter int AW       = 12,
   parameter int W_BASE   = 0,
   parameter int A_BASE   = 16,
   parameter int DRAIN_TO = 64
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              reload_w,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_rd,
   output logic [AW-1:0]     mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              weight_vld,
   output logic [DATA_W-1:0] weight,
   output logic              ce,
   output logic [DATA_W-1:0] activation,
   input  logic              valid_conv,
   input  logic              end_conv
);

   // state  | meaning
   // IDLE   | waiting for start
   // LOAD_W | issuing NW kernel reads
   // FEED_A | issuing NA activation reads back to back
   // DRAIN  | waiting for end_conv or timeout
   // DONE   | done pulse, status valid

   localparam int NW    = calc_nw(K);
   localparam int NA    = calc_na(FM_ROW, FM_COL);
   localparam int OUT_N = calc_out_n(FM_ROW, FM_COL, K, S);
   localparam int RD_W  = cnt_w((NW > NA) ? NW : NA);
   localparam int TO_W  = cnt_w(DRAIN_TO);
   localparam int OC_W  = cnt_w(NA + DRAIN_TO);

   state_t            state;
   state_t            state_nxt;
   logic [RD_W-1:0]   rd_left;
   logic [RD_W-1:0]   rd_left_nxt;
   logic [TO_W-1:0]   to_left;
   logic [TO_W-1:0]   to_left_nxt;
   logic [AW-1:0]     addr_nxt;
   logic              rd_nxt;
   logic              rd_is_w;
   logic              rd_is_w_nxt;
   logic              fin;
   logic              timeout;

   logic              w_loaded;
   logic [OC_W-1:0]   out_cnt;
   logic [OC_W-1:0]   out_cnt_fin;
   logic              ce_seen;
   logic              early_vld;
   logic              early_now;
   logic              end_seen;
   logic              cnt_en;
   logic              accept;

   assign weight     = mem_rdata;
   assign activation = mem_rdata;

   assign accept      = (state == IDLE) && start;
   assign cnt_en      = (state == FEED_A) || (state == DRAIN);
   assign early_now   = valid_conv && !ce_seen && !ce && (cnt_en || (state == LOAD_W));
   assign out_cnt_fin = out_cnt + {{(OC_W-1){1'b0}}, (cnt_en && valid_conv)};

   always_comb begin
      state_nxt   = state;
      rd_left_nxt = rd_left;
      to_left_nxt = to_left;
      addr_nxt    = mem_addr;
      rd_nxt      = mem_rd;
      rd_is_w_nxt = rd_is_w;
      fin         = 1'b0;
      timeout     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               rd_nxt = 1'b1;
               if (reload_w || !w_loaded) begin
                  state_nxt   = LOAD_W;
                  rd_is_w_nxt = 1'b1;
                  addr_nxt    = AW'(W_BASE);
                  rd_left_nxt = RD_W'(NW - 1);
               end else begin
                  state_nxt   = FEED_A;
                  rd_is_w_nxt = 1'b0;
                  addr_nxt    = AW'(A_BASE);
                  rd_left_nxt = RD_W'(NA - 1);
               end
            end
         end
         LOAD_W: begin
            // Hand over straight to the activation reads so ce follows weight_vld with no gap.
            if (rd_left == '0) begin
               state_nxt   = FEED_A;
               rd_is_w_nxt = 1'b0;
               addr_nxt    = AW'(A_BASE);
               rd_left_nxt = RD_W'(NA - 1);
            end else begin
               addr_nxt    = mem_addr + AW'(1);
               rd_left_nxt = rd_left - RD_W'(1);
            end
         end
         FEED_A: begin
            if (rd_left == '0) begin
               state_nxt   = DRAIN;
               rd_nxt      = 1'b0;
               to_left_nxt = TO_W'(DRAIN_TO - 1);
            end else begin
               addr_nxt    = mem_addr + AW'(1);
               rd_left_nxt = rd_left - RD_W'(1);
            end
         end
         DRAIN: begin
            if (end_conv || end_seen) begin
               state_nxt = DONE;
               fin       = 1'b1;
            end else if (to_left == '0) begin
               state_nxt = DONE;
               fin       = 1'b1;
               timeout   = 1'b1;
            end else begin
               to_left_nxt = to_left - TO_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            rd_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rd_left    <= '0;
         to_left    <= '0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         rd_is_w    <= 1'b0;
         weight_vld <= 1'b0;
         ce         <= 1'b0;
      end else begin
         state      <= state_nxt;
         rd_left    <= rd_left_nxt;
         to_left    <= to_left_nxt;
         mem_rd     <= rd_nxt;
         mem_addr   <= addr_nxt;
         rd_is_w    <= rd_is_w_nxt;
         // Strobes mark the cycle the buffer data for the previous read is on mem_rdata.
         weight_vld <= mem_rd && rd_is_w;
         ce         <= mem_rd && !rd_is_w;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         w_loaded  <= 1'b0;
         out_cnt   <= '0;
         ce_seen   <= 1'b0;
         early_vld <= 1'b0;
         end_seen  <= 1'b0;
      end else begin
         done <= fin;
         if (accept) begin
            busy      <= 1'b1;
            err       <= 1'b0;
            out_cnt   <= '0;
            ce_seen   <= 1'b0;
            early_vld <= 1'b0;
            end_seen  <= 1'b0;
         end else begin
            out_cnt <= out_cnt_fin;
            if (ce) begin
               ce_seen <= 1'b1;
            end
            if (early_now) begin
               early_vld <= 1'b1;
            end
            if ((state == FEED_A) && end_conv) begin
               end_seen <= 1'b1;
            end
            if ((state == LOAD_W) && (rd_left == '0)) begin
               w_loaded <= 1'b1;
            end
            if (fin) begin
               err <= timeout || (out_cnt_fin != OC_W'(OUT_N)) || early_vld || early_now;
            end
            if (state == DONE) begin
               busy <= 1'b0;
            end
         end
      end
   end

endmodule
